// File: rtl/contador_minutos_segundos.sv
// -----------------------------------------------------------------------------
// contador_minutos_segundos
//
// Seconds/minutes stage of the digital clock. A prescaler divides clk down to
// one advance every DIV cycles; seconds and minutes are kept as BCD digit
// pairs in the range 00..59. A set mode lets the user step the minutes by hand
// without disturbing the downstream hours counter.
//
// Parameters
//   DIV          clk cycles per one-second advance (>= 2)
//
// Ports
//   clk          system clock, rising-edge
//   rst          asynchronous reset, active high
//   enable       0 freezes prescaler, digits and zera_seg action
//   ajuste       set mode: timekeeping halted, inc_min steps minutes
//   inc_min      debounced button level; each 0->1 edge adds one minute
//   zera_seg     level; holds seconds and prescaler at zero
//   seg_unidade  seconds units (BCD 0..9)
//   seg_dezena   seconds tens (0..5)
//   min_unidade  minutes units (BCD 0..9)
//   min_dezena   minutes tens (0..5)
//   tick_1hz     one-cycle pulse, aligned with each new seconds value
//   carry_out    one-cycle pulse, aligned with the 59:59 -> 00:00 rollover
// -----------------------------------------------------------------------------
module contador_minutos_segundos #(
   parameter int unsigned DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       ajuste,
   input  logic       inc_min,
   input  logic       zera_seg,
   output logic [3:0] seg_unidade,
   output logic [2:0] seg_dezena,
   output logic [3:0] min_unidade,
   output logic [2:0] min_dezena,
   output logic       tick_1hz,
   output logic       carry_out
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   // Operating mode, decoded in priority order: a frozen block ignores
   // everything, clearing seconds beats set mode, set mode beats counting.
   typedef enum logic [1:0] {
      MODE_HOLD,
      MODE_CLEAR,
      MODE_SET,
      MODE_RUN
   } mode_e;

   mode_e            mode;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       su_q, su_d;
   logic [2:0]       st_q, st_d;
   logic [3:0]       mu_q, mu_d;
   logic [2:0]       mt_q, mt_d;
   logic             tick_q, tick_d;
   logic             carry_q, carry_d;
   logic             inc_prev_q;

   logic             inc_edge;
   logic             cnt_wrap;
   logic             sec_at_max;
   logic             min_at_max;
   logic             min_step;

   // Advance a BCD 00..59 pair by one, wrapping 59 back to 00.
   function automatic logic [6:0] bcd59_inc(input logic [2:0] tens,
                                            input logic [3:0] units);
      logic [2:0] t;
      logic [3:0] u;
      t = tens;
      u = units;
      if (units == 4'd9) begin
         u = 4'd0;
         t = (tens == 3'd5) ? 3'd0 : tens + 3'd1;
      end else begin
         u = units + 4'd1;
      end
      return {t, u};
   endfunction

   always_comb begin
      if (!enable) begin
         mode = MODE_HOLD;
      end else if (zera_seg) begin
         mode = MODE_CLEAR;
      end else if (ajuste) begin
         mode = MODE_SET;
      end else begin
         mode = MODE_RUN;
      end
   end

   // The edge register samples inc_min every cycle regardless of enable, so
   // a button already held when the block is re-enabled never looks like a
   // fresh press.
   assign inc_edge   = inc_min & ~inc_prev_q;
   assign cnt_wrap   = (cnt_q == CNT_MAX);
   assign sec_at_max = (st_q == 3'd5) && (su_q == 4'd9);
   assign min_at_max = (mt_q == 3'd5) && (mu_q == 4'd9);

   always_comb begin
      cnt_d    = cnt_q;
      su_d     = su_q;
      st_d     = st_q;
      mu_d     = mu_q;
      mt_d     = mt_q;
      tick_d   = 1'b0;
      carry_d  = 1'b0;
      min_step = 1'b0;

      unique case (mode)
         MODE_HOLD: begin
         end
         MODE_CLEAR: begin
            // Seconds held at zero; manual minute steps still honoured in
            // set mode but never produce a carry.
            cnt_d    = '0;
            su_d     = '0;
            st_d     = '0;
            min_step = ajuste & inc_edge;
         end
         MODE_SET: begin
            cnt_d    = '0;
            min_step = inc_edge;
         end
         MODE_RUN: begin
            if (cnt_wrap) begin
               cnt_d        = '0;
               {st_d, su_d} = bcd59_inc(st_q, su_q);
               tick_d       = 1'b1;
               if (sec_at_max) begin
                  min_step = 1'b1;
                  carry_d  = min_at_max;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase

      if (min_step) begin
         {mt_d, mu_d} = bcd59_inc(mt_q, mu_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         su_q       <= '0;
         st_q       <= '0;
         mu_q       <= '0;
         mt_q       <= '0;
         tick_q     <= 1'b0;
         carry_q    <= 1'b0;
         inc_prev_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         su_q       <= su_d;
         st_q       <= st_d;
         mu_q       <= mu_d;
         mt_q       <= mt_d;
         tick_q     <= tick_d;
         carry_q    <= carry_d;
         inc_prev_q <= inc_min;
      end
   end

   assign seg_unidade = su_q;
   assign seg_dezena  = st_q;
   assign min_unidade = mu_q;
   assign min_dezena  = mt_q;
   assign tick_1hz    = tick_q;
   assign carry_out   = carry_q;

endmodule

// File: tb/tb_contador_minutos_segundos.sv
// -----------------------------------------------------------------------------
// tb_contador_minutos_segundos
//
// Directed stimulus for the seconds/minutes stage with DIV=4. The stimulus
// process pushes the expected ticks (cycle, time, carry) and expected static
// snapshots into queues; an independent monitor on the falling edge pops and
// compares them against what the DUT presents.
// -----------------------------------------------------------------------------
module tb_contador_minutos_segundos;

   localparam int unsigned DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       ajuste;
   logic       inc_min;
   logic       zera_seg;
   logic [3:0] seg_unidade;
   logic [2:0] seg_dezena;
   logic [3:0] min_unidade;
   logic [2:0] min_dezena;
   logic       tick_1hz;
   logic       carry_out;

   contador_minutos_segundos #(.DIV(DIV)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .ajuste      (ajuste),
      .inc_min     (inc_min),
      .zera_seg    (zera_seg),
      .seg_unidade (seg_unidade),
      .seg_dezena  (seg_dezena),
      .min_unidade (min_unidade),
      .min_dezena  (min_dezena),
      .tick_1hz    (tick_1hz),
      .carry_out   (carry_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int mm;
      int ss;
      bit carry;
   } tick_t;

   typedef struct {
      string name;
      int    mm;
      int    ss;
   } probe_t;

   tick_t  exp_ticks[$];
   probe_t exp_probes[$];

   int checks = 0;
   int errors = 0;
   int t_sec  = 0;   // reference time in seconds, 0..3599

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      tick_t  e;
      probe_t p;
      int     mm;
      int     ss;
      mm = int'(min_dezena) * 10 + int'(min_unidade);
      ss = int'(seg_dezena) * 10 + int'(seg_unidade);

      while (exp_ticks.size() > 0 && exp_ticks[0].cyc < cyc) begin
         e = exp_ticks.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_tick: no tick at cycle %0d, required %02d:%02d carry=%0b",
                  e.cyc, e.mm, e.ss, e.carry);
      end

      if (exp_ticks.size() > 0 && exp_ticks[0].cyc == cyc) begin
         e = exp_ticks.pop_front();
         checks++;
         if (!(tick_1hz === 1'b1 && mm == e.mm && ss == e.ss && carry_out === e.carry)) begin
            errors++;
            $display("FAIL tick@%0d: got tick=%0b %02d:%02d carry=%0b, required tick=1 %02d:%02d carry=%0b",
                     cyc, tick_1hz, mm, ss, carry_out, e.mm, e.ss, e.carry);
         end
      end else if (tick_1hz !== 1'b0 || carry_out !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL stray_pulse@%0d: got tick=%0b carry=%0b at %02d:%02d, required none",
                  cyc, tick_1hz, carry_out, mm, ss);
      end

      if (exp_probes.size() > 0) begin
         p = exp_probes.pop_front();
         checks++;
         if (!(mm == p.mm && ss == p.ss && tick_1hz === 1'b0 && carry_out === 1'b0)) begin
            errors++;
            $display("FAIL %s: got %02d:%02d tick=%0b carry=%0b, required %02d:%02d tick=0 carry=0",
                     p.name, mm, ss, tick_1hz, carry_out, p.mm, p.ss);
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name);
      probe_t p;
      p.name = name;
      p.mm   = t_sec / 60;
      p.ss   = t_sec % 60;
      exp_probes.push_back(p);
   endtask

   task automatic add_minute();
      t_sec = (((t_sec / 60) + 1) % 60) * 60 + (t_sec % 60);
   endtask

   task automatic pulse_min(input int n);
      for (int i = 0; i < n; i++) begin
         inc_min = 1'b1;
         step(1);
         inc_min = 1'b0;
         step(1);
         add_minute();
      end
   endtask

   // Start free counting from a zero prescaler and queue n expected ticks.
   task automatic run_ticks(input int n, input bit stop);
      tick_t e;
      int    c0;
      enable   = 1'b1;
      ajuste   = 1'b0;
      zera_seg = 1'b0;
      c0 = cyc;
      for (int i = 1; i <= n; i++) begin
         t_sec   = (t_sec + 1) % 3600;
         e.cyc   = c0 + int'(DIV) * i;
         e.mm    = t_sec / 60;
         e.ss    = t_sec % 60;
         e.carry = (t_sec == 0);
         exp_ticks.push_back(e);
      end
      step(int'(DIV) * n);
      if (stop) enable = 1'b0;
   endtask

   // --------------------------------------------------------------- stimulus
   initial begin
      rst      = 1'b1;
      enable   = 1'b0;
      ajuste   = 1'b0;
      inc_min  = 1'b0;
      zera_seg = 1'b0;

      // Reset and idle with enable low
      step(2);
      probe("reset_state");
      rst = 1'b0;
      step(20);
      probe("idle_frozen");
      step(1);

      // Free count: 00:40 at tick 40, 01:00 without carry at tick 60
      run_ticks(62, 1'b0);
      // ajuste arrives on the same edge as the prescaler wrap: no advance
      step(3);
      ajuste = 1'b1;
      step(1);
      probe("ajuste_at_wrap");

      // Set mode: 59 steps wrap minutes to 00 with no carry, 61 more give 01
      pulse_min(59);
      probe("set_wrap_no_carry");
      pulse_min(61);
      probe("set_61_pulses");
      inc_min = 1'b1;
      step(10);
      inc_min = 1'b0;
      step(1);
      add_minute();
      probe("held_counts_once");

      // Rollover: preload 59:02, count through 59:58, 59:59, 00:00 + carry
      pulse_min(57);
      probe("preload_59");
      run_ticks(58, 1'b1);
      step(1);
      probe("after_rollover");

      // zera_seg collides with the wrap at 00:59
      run_ticks(59, 1'b0);
      step(3);
      zera_seg = 1'b1;
      step(1);
      t_sec = (t_sec / 60) * 60;
      probe("zera_collision");
      step(2);
      run_ticks(2, 1'b1);
      step(1);

      // Set 12:00 with seconds cleared, then count to 12:34
      enable   = 1'b1;
      ajuste   = 1'b1;
      zera_seg = 1'b1;
      t_sec    = (t_sec / 60) * 60;
      pulse_min(12);
      zera_seg = 1'b0;
      step(1);
      probe("set_12_00");
      run_ticks(34, 1'b0);

      // Asynchronous reset between edges, mid-count
      step(2);
      rst   = 1'b1;
      t_sec = 0;
      probe("async_reset");
      step(2);
      rst = 1'b0;
      run_ticks(1, 1'b1);
      step(1);

      // Button held across re-enable must not count
      ajuste  = 1'b1;
      inc_min = 1'b1;
      step(3);
      enable = 1'b1;
      step(3);
      inc_min = 1'b0;
      step(1);
      probe("held_across_enable");
      step(4);

      while (exp_ticks.size() > 0) begin
         tick_t e;
         e = exp_ticks.pop_front();
         checks++;
         errors++;
         $display("FAIL pending_tick: not observed by cycle %0d, required %02d:%02d at cycle %0d",
                  cyc, e.mm, e.ss, e.cyc);
      end
      while (exp_probes.size() > 0) begin
         probe_t p;
         p = exp_probes.pop_front();
         checks++;
         errors++;
         $display("FAIL pending_probe: %s never sampled", p.name);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
